// File: rtl/charge_pump_pkg.sv
// Shared state encoding, mode constants and phase codes for the charge-pump sequencer.
// No timing and no flow control; definitions only.
package charge_pump_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_SNK  = 2'd2,
    ST_SRC  = 2'd3
  } cp_state_e;

  localparam logic [1:0] MODE_ALT  = 2'd0;
  localparam logic [1:0] MODE_SNK  = 2'd1;
  localparam logic [1:0] MODE_SRC  = 2'd2;
  localparam logic [1:0] MODE_ALT3 = 2'd3;

  localparam logic [1:0] PH_IDLE = 2'd0;
  localparam logic [1:0] PH_PRE  = 2'd1;
  localparam logic [1:0] PH_SNK  = 2'd2;
  localparam logic [1:0] PH_SRC  = 2'd3;

  // Code 3 behaves as alternate, so fold it once at latch time.
  function automatic logic [1:0] norm_mode(input logic [1:0] m);
    return (m == MODE_ALT3) ? MODE_ALT : m;
  endfunction

endpackage

// File: rtl/cp_phase_timer.sv
// Phase-length down counter: load a length, count to zero, flag terminal count.
// Terminal flag is combinational from the count register; no backpressure.
module cp_phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic             i_dec,
  input  logic [CNT_W-1:0] i_len,
  output logic             o_tc
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_len;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_tc = (r_cnt == '0);

endmodule

// File: rtl/charge_pump_seq.sv
// Charge-pump switch sequencer: precharge, then sink/source pump phases for a burst of periods.
// All outputs registered, one cycle from sampled inputs; free-running, no backpressure.
module charge_pump_seq
  import charge_pump_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int BURST_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [1:0]         mode,
  input  logic [CNT_W-1:0]   pre_len,
  input  logic [CNT_W-1:0]   snk_len,
  input  logic [CNT_W-1:0]   src_len,
  input  logic [BURST_W-1:0] burst,
  output logic               snk,
  output logic               src_n,
  output logic               preChrg,
  output logic               rst,
  output logic               busy,
  output logic               done,
  output logic [1:0]         phase
);

  cp_state_e          r_state;
  cp_state_e          w_state_nxt;
  logic [1:0]         r_mode;
  logic [CNT_W-1:0]   r_snk_len;
  logic [CNT_W-1:0]   r_src_len;
  logic [BURST_W-1:0] r_burst;
  logic [BURST_W-1:0] r_period_cnt;
  logic [BURST_W-1:0] w_cnt_inc;
  logic               r_snk, r_src_n, r_pre, r_busy, r_done, r_rst;
  logic               w_snk_nxt, w_src_n_nxt, w_pre_nxt, w_busy_nxt, w_done_nxt;
  logic               w_tc, w_start, w_period_end, w_burst_hit, w_phase_start;
  logic [CNT_W-1:0]   w_tmr_len;

  assign w_start      = (r_state == ST_IDLE) && en;
  assign w_cnt_inc    = r_period_cnt + BURST_W'(1);
  assign w_burst_hit  = (r_burst != '0) && (w_cnt_inc == r_burst);
  // A period closes at the end of SRC, or of SNK when running sink-only.
  assign w_period_end = en && w_tc &&
                        ((r_state == ST_SRC) || ((r_state == ST_SNK) && (r_mode == MODE_SNK)));
  assign w_phase_start = (w_state_nxt != ST_IDLE) && ((w_state_nxt != r_state) || w_tc);

  // Precharge is only entered from IDLE, so its length comes straight from the input.
  assign w_tmr_len = (w_state_nxt == ST_PRE) ? pre_len :
                     (w_state_nxt == ST_SNK) ? r_snk_len : r_src_len;

  cp_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_phase_start),
    .i_dec  (r_state != ST_IDLE),
    .i_len  (w_tmr_len),
    .o_tc   (w_tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_mode       <= MODE_ALT;
      r_snk_len    <= '0;
      r_src_len    <= '0;
      r_burst      <= '0;
      r_period_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_mode       <= norm_mode(mode);
        r_snk_len    <= snk_len;
        r_src_len    <= src_len;
        r_burst      <= burst;
        r_period_cnt <= '0;
      end else if (w_period_end && (r_period_cnt != '1)) begin
        r_period_cnt <= w_cnt_inc;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == ST_IDLE) begin
      if (en) w_state_nxt = ST_PRE;
    end else if (!en) begin
      w_state_nxt = ST_IDLE;
    end else if (w_tc) begin
      case (r_state)
        ST_PRE:  w_state_nxt = (r_mode == MODE_SRC) ? ST_SRC : ST_SNK;
        ST_SNK:  w_state_nxt = (w_period_end && w_burst_hit) ? ST_IDLE :
                               (r_mode == MODE_SNK) ? ST_SNK : ST_SRC;
        ST_SRC:  w_state_nxt = (w_period_end && w_burst_hit) ? ST_IDLE :
                               (r_mode == MODE_SRC) ? ST_SRC : ST_SNK;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Each phase restarts its toggle pattern, including back-to-back same-type phases.
  always_comb begin
    w_snk_nxt   = 1'b0;
    w_src_n_nxt = 1'b1;
    w_pre_nxt   = (w_state_nxt == ST_PRE);
    w_busy_nxt  = (w_state_nxt != ST_IDLE);
    w_done_nxt  = w_period_end && w_burst_hit;
    if (w_state_nxt == ST_SNK) w_snk_nxt   = w_phase_start ? 1'b1 : ~r_snk;
    if (w_state_nxt == ST_SRC) w_src_n_nxt = w_phase_start ? 1'b0 : ~r_src_n;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_snk   <= 1'b0;
      r_src_n <= 1'b1;
      r_pre   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_rst   <= 1'b1;
    end else begin
      r_snk   <= w_snk_nxt;
      r_src_n <= w_src_n_nxt;
      r_pre   <= w_pre_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_rst   <= 1'b0;
    end
  end

  assign snk     = r_snk;
  assign src_n   = r_src_n;
  assign preChrg = r_pre;
  assign busy    = r_busy;
  assign done    = r_done;
  assign rst     = r_rst;
  assign phase   = r_state;

endmodule

// File: tb/tb_charge_pump_seq.sv
// Directed bench for charge_pump_seq: per-cycle vector table plus hand sequences for corner cases.
module tb_charge_pump_seq;

  logic       clk = 1'b0;
  logic       reset, en, en4;
  logic [1:0] mode, mode4;
  logic [7:0] pre_len, snk_len, src_len, burst, burst4;
  logic [3:0] pre_len4, snk_len4, src_len4;
  logic       snk, src_n, preChrg, rst, busy, done;
  logic       snk4, src_n4, preChrg4, rst4, busy4, done4;
  logic [1:0] phase, phase4;
  logic [6:0] obs;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  charge_pump_seq u_dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .pre_len(pre_len),
    .snk_len(snk_len), .src_len(src_len), .burst(burst),
    .snk(snk), .src_n(src_n), .preChrg(preChrg), .rst(rst),
    .busy(busy), .done(done), .phase(phase)
  );

  charge_pump_seq #(.CNT_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .en(en4), .mode(mode4), .pre_len(pre_len4),
    .snk_len(snk_len4), .src_len(src_len4), .burst(burst4),
    .snk(snk4), .src_n(src_n4), .preChrg(preChrg4), .rst(rst4),
    .busy(busy4), .done(done4), .phase(phase4)
  );

  assign obs = {snk, src_n, preChrg, busy, done, phase};

  // Expected output bundles {snk, src_n, preChrg, busy, done, phase}
  localparam logic [6:0] E_IDLE  = 7'b0100000;
  localparam logic [6:0] E_DONE  = 7'b0100100;
  localparam logic [6:0] E_PRE   = 7'b0111001;
  localparam logic [6:0] E_SNK1  = 7'b1101010;
  localparam logic [6:0] E_SNK0  = 7'b0101010;
  localparam logic [6:0] E_SRC0  = 7'b0001011;
  localparam logic [6:0] E_SRC1  = 7'b0101011;

  typedef struct {
    logic       en;
    logic [1:0] mode;
    logic [7:0] pre, sl, rl, bst;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic add(input logic e, input logic [1:0] m, input logic [7:0] p, input logic [7:0] s,
                     input logic [7:0] r, input logic [7:0] b, input logic [6:0] x);
    vec_t v;
    v.en = e; v.mode = m; v.pre = p; v.sl = s; v.rl = r; v.bst = b; v.exp = x;
    vecs.push_back(v);
  endtask

  always @(negedge clk) begin
    check("excl", {28'd0, snk & ~src_n, preChrg & (snk | ~src_n),
                   snk4 & ~src_n4, preChrg4 & (snk4 | ~src_n4)}, 32'd0);
  end

  initial begin
    int k;
    int bad;
    int pre_cnt;
    reset = 1'b0; en = 1'b0; en4 = 1'b0;
    mode = 2'd0; pre_len = 8'd0; snk_len = 8'd0; src_len = 8'd0; burst = 8'd0;
    mode4 = 2'd1; pre_len4 = 4'd15; snk_len4 = 4'd0; src_len4 = 4'd0; burst4 = 8'd1;
    #1 reset = 1'b1;
    #2;
    check("reset_outputs", obs, E_IDLE);
    check("reset_rst", rst, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    check("rst_release", rst, 1'b0);
    check("idle_after_release", obs, E_IDLE);

    // Alternate, pre 3, snk 2, src 2, burst 2
    repeat (4) add(1, 0, 3, 2, 2, 2, E_PRE);
    for (int p = 0; p < 2; p++) begin
      add(1, 0, 3, 2, 2, 2, E_SNK1); add(1, 0, 3, 2, 2, 2, E_SNK0); add(1, 0, 3, 2, 2, 2, E_SNK1);
      add(1, 0, 3, 2, 2, 2, E_SRC0); add(1, 0, 3, 2, 2, 2, E_SRC1); add(1, 0, 3, 2, 2, 2, E_SRC0);
    end
    add(1, 0, 3, 2, 2, 2, E_DONE);
    add(0, 0, 3, 2, 2, 2, E_IDLE);
    // Sink-only, one-cycle phases, burst 3
    add(1, 1, 0, 0, 5, 3, E_PRE);
    repeat (3) add(1, 1, 0, 0, 5, 3, E_SNK1);
    add(1, 1, 0, 0, 5, 3, E_DONE);
    add(0, 1, 0, 0, 5, 3, E_IDLE);
    // Mode 3 acts as alternate; inputs changed mid-sequence are ignored
    add(1, 3, 0, 3, 0, 1, E_PRE);
    add(1, 1, 0, 0, 0, 5, E_SNK1); add(1, 1, 0, 0, 0, 5, E_SNK0);
    add(1, 1, 0, 0, 0, 5, E_SNK1); add(1, 1, 0, 0, 0, 5, E_SNK0);
    add(1, 1, 0, 0, 0, 5, E_SRC0);
    add(1, 1, 0, 0, 0, 5, E_DONE);
    add(0, 1, 0, 0, 0, 5, E_IDLE);
    // Abort by dropping en mid-SRC: no done
    add(1, 0, 1, 1, 1, 0, E_PRE); add(1, 0, 1, 1, 1, 0, E_PRE);
    add(1, 0, 1, 1, 1, 0, E_SNK1); add(1, 0, 1, 1, 1, 0, E_SNK0);
    add(1, 0, 1, 1, 1, 0, E_SRC0);
    add(0, 0, 1, 1, 1, 0, E_IDLE);
    add(0, 0, 1, 1, 1, 0, E_IDLE);
    // Source-only burst 1, en held high across done restarts the sequence
    add(1, 2, 0, 0, 0, 1, E_PRE); add(1, 2, 0, 0, 0, 1, E_SRC0); add(1, 2, 0, 0, 0, 1, E_DONE);
    add(1, 2, 0, 0, 0, 1, E_PRE); add(1, 2, 0, 0, 0, 1, E_SRC0); add(1, 2, 0, 0, 0, 1, E_DONE);
    add(0, 2, 0, 0, 0, 1, E_IDLE);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      en = vecs[i].en; mode = vecs[i].mode; pre_len = vecs[i].pre;
      snk_len = vecs[i].sl; src_len = vecs[i].rl; burst = vecs[i].bst;
      @(posedge clk); #1;
      check($sformatf("vec%0d", i), obs, vecs[i].exp);
    end

    // Source-only continuous run: period counter passes 255 without ending the burst
    @(negedge clk);
    mode = 2'd2; pre_len = 8'd0; src_len = 8'd0; burst = 8'd0; en = 1'b1;
    bad = 0;
    repeat (300) begin
      @(posedge clk); #1;
      if (done || !busy) bad++;
    end
    check("burst0_continuous", bad, 0);
    @(negedge clk) en = 1'b0;
    @(posedge clk); #1;
    check("burst0_en_drop", obs, E_IDLE);

    // Narrow counter: pre_len all-ones gives exactly 16 precharge cycles
    @(negedge clk) en4 = 1'b1;
    pre_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (phase4 == 2'd1) pre_cnt++;
      else break;
    end
    check("cnt4_pre_cycles", pre_cnt, 16);
    check("cnt4_then_snk", {snk4, phase4}, 3'b110);
    @(posedge clk); #1;
    check("cnt4_done", {done4, busy4, phase4}, 4'b1000);
    @(negedge clk) en4 = 1'b0;

    // Asynchronous reset in the middle of a source phase
    @(negedge clk);
    mode = 2'd2; pre_len = 8'd2; src_len = 8'd3; burst = 8'd0; en = 1'b1;
    k = 0;
    while (phase != 2'd3 && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check("reach_src", phase, 2'd3);
    #1 reset = 1'b1;
    #1;
    check("async_reset_outputs", obs, E_IDLE);
    check("async_reset_rst", rst, 1'b1);
    en = 1'b0;
    @(negedge clk);
    check("rst_held", rst, 1'b1);
    reset = 1'b0;
    @(posedge clk); #1;
    check("rst_after_release", {rst, done, phase}, 4'b0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/charge_pump_seq.md
CHARGE_PUMP_SEQ -- requirements
Module: charge_pump_seq

Interface
REQ-001 Parameter CNT_W, default 8, width of the phase-length counters and inputs.
REQ-002 Parameter BURST_W, default 8, width of the burst counter and input.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 en  input  1  level enable; rising into 1 while IDLE starts a sequence.
REQ-006 mode  input  2  0 = alternate SNK/SRC, 1 = sink-only, 2 = source-only, 3 = treated as 0.
REQ-007 pre_len  input  CNT_W  precharge length; phase lasts pre_len+1 cycles.
REQ-008 snk_len  input  CNT_W  sink phase length; lasts snk_len+1 cycles.
REQ-009 src_len  input  CNT_W  source phase length; lasts src_len+1 cycles.
REQ-010 burst  input  BURST_W  number of pump periods; 0 = continuous until en low.
REQ-011 snk  output  1  sink switch drive, active high.
REQ-012 src_n  output  1  source switch drive, active low.
REQ-013 preChrg  output  1  precharge switch drive, active high.
REQ-014 rst  output  1  registered reset flag to the analog core.
REQ-015 busy  output  1  high in PRECHARGE, SNK, SRC.
REQ-016 done  output  1  one-cycle pulse on burst completion.
REQ-017 phase  output  2  current state code (IDLE=0, PRECHARGE=1, SNK=2, SRC=3).

Function
REQ-018 States IDLE, PRECHARGE, SNK, SRC; all outputs registered.
REQ-019 IDLE: snk=0, src_n=1, preChrg=0, busy=0; leaves to PRECHARGE on the cycle after en=1 is sampled.
REQ-020 On leaving IDLE, mode, pre_len, snk_len, src_len, burst are latched; changes during a sequence are ignored.
REQ-021 PRECHARGE: preChrg=1, snk=0, src_n=1 for exactly pre_len+1 cycles, then to first pump phase (SRC if mode=2, else SNK), preChrg=0.
REQ-022 SNK: src_n=1; snk toggles every cycle starting at 1; exactly snk_len+1 cycles; snk forced 0 on exit.
REQ-023 SRC: snk=0; src_n toggles every cycle starting at 0; exactly src_len+1 cycles; src_n forced 1 on exit.
REQ-024 Alternate mode: SNK->SRC->SNK...; one period = one SNK plus one SRC phase; sink-only: SNK->SNK; source-only: SRC->SRC, one phase = one period.
REQ-025 Period counter increments at each period end; when count equals burst (burst!=0) go to IDLE and pulse done for one cycle, same edge outputs take IDLE values.
REQ-026 burst=0: counter does not terminate the sequence; counter saturates at all-ones, no wrap.
REQ-027 en sampled low in any non-IDLE state: next cycle IDLE, idle output values, done not asserted.
REQ-028 en held high after done: new sequence starts from PRECHARGE the cycle after IDLE is entered.
REQ-029 snk=1 and src_n=0 never simultaneously; preChrg never high with snk=1 or src_n=0.
REQ-030 Length inputs of 0 give one-cycle phases; all-ones give 2^CNT_W cycles without overflow.

Reset
REQ-031 reset=1 asynchronously forces IDLE, snk=0, src_n=1, preChrg=0, busy=0, done=0, phase=0, counters 0, rst=1.
REQ-032 rst deasserts on the first clk edge with reset low; reset mid-phase aborts with no done pulse.

Structure
REQ-033 Package charge_pump_pkg holds the state enum, mode constants and phase codes.
REQ-034 One sub-module cp_phase_timer (load length, count down, terminal-count flag) reused for all phases.

Verification
REQ-035 mode=0, pre_len=3, snk_len=2, src_len=2, burst=2, en=1 -> preChrg high 4 cycles, snk 1,0,1 then src_n 0,1,0, twice, done one cycle, busy low after.
REQ-036 mode=1, snk_len=0, burst=3 -> snk high one cycle per SNK phase, three phases, src_n constant 1, done once.
REQ-037 mode=2, burst=0, en dropped after 20 cycles -> IDLE next cycle, src_n=1, no done.
REQ-038 reset asserted mid-SRC -> outputs idle asynchronously, rst=1, rst low one edge after release.
REQ-039 snk_len changed during SNK -> phase length unchanged; mutual-exclusion assertion REQ-029 holds throughout.
REQ-040 CNT_W=4, pre_len=15 -> precharge exactly 16 cycles, no wrap.
